// File: rtl/sd_lane_sreg_pkg.sv
// ============================================================================
// Module   : sd_sreg_pkg
// Brief    : Shared types and helpers for the SD lane shift register.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sd_sreg_pkg;

  localparam int SD_LANES = 4;

  typedef enum logic {
    SD_BUS_1BIT = 1'b0,
    SD_BUS_4BIT = 1'b1
  } sd_bus_width_t;

  // Shift strobes needed to move one full word through the register.
  function automatic int sd_shift_count(input int width, input sd_bus_width_t bus);
    return (bus == SD_BUS_4BIT) ? (width / SD_LANES) : width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_lane_sreg_cnt.sv
// ============================================================================
// Module   : sd_sreg_cnt
// Brief    : Loadable down-counter with busy and single-cycle done generation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_sreg_cnt #(
  parameter int CW = 5
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          busy_o,
  output logic          done_o
);

  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          w_dec;
  logic          w_last;

  assign w_dec  = r_busy & dec_i;
  assign w_last = w_dec & (r_cnt == CW'(1));

  // Load has priority so a reload in the done cycle starts the next word gap-free.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (load_i) begin
      r_cnt  <= load_val_i;
      r_busy <= (load_val_i != '0);
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_dec) begin
        r_cnt  <= r_cnt - CW'(1);
        r_busy <= ~w_last;
      end
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

`default_nettype wire

// File: rtl/sd_lane_sreg.sv
// ============================================================================
// Module   : sd_lane_sreg
// Brief    : 1/4-lane SD parallel/serial shift register with word counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_lane_sreg
  import sd_sreg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic             wide_i,
  input  logic [WIDTH-1:0] data_p_i,
  input  logic [3:0]       data_s_i,
  output logic [WIDTH-1:0] data_p_o,
  output logic [3:0]       data_s_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_CNT_NARROW = CW'(sd_shift_count(WIDTH, SD_BUS_1BIT));
  localparam logic [CW-1:0] c_CNT_WIDE   = CW'(sd_shift_count(WIDTH, SD_BUS_4BIT));

  if ((WIDTH % SD_LANES) != 0 || WIDTH < 8) begin : g_bad_width
    $error("sd_lane_sreg: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [WIDTH-1:0] r_sr;
  sd_bus_width_t    r_bus;
  logic [CW-1:0]    w_load_cnt;

  assign w_load_cnt = wide_i ? c_CNT_WIDE : c_CNT_NARROW;

  // Shifting continues with the counter idle so start bits and CRC can be hunted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sr  <= '0;
      r_bus <= SD_BUS_1BIT;
    end else if (load_i) begin
      r_sr  <= data_p_i;
      r_bus <= sd_bus_width_t'(wide_i);
    end else if (shift_en_i) begin
      if (r_bus == SD_BUS_4BIT) begin
        r_sr <= {r_sr[WIDTH-5:0], data_s_i};
      end else begin
        r_sr <= {r_sr[WIDTH-2:0], data_s_i[0]};
      end
    end
  end

  assign data_p_o = r_sr;
  assign data_s_o = (r_bus == SD_BUS_4BIT) ? r_sr[WIDTH-1:WIDTH-4]
                                            : {3'b111, r_sr[WIDTH-1]};

  sd_sreg_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (load_i),
    .load_val_i (w_load_cnt),
    .dec_i      (shift_en_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_sd_lane_sreg.sv
// ============================================================================
// Module   : tb_sd_lane_sreg
// Brief    : Directed scoreboard bench for sd_lane_sreg at WIDTH=16.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sd_lane_sreg;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         load;
  logic         shift_en;
  logic         wide;
  logic [W-1:0] dp_i;
  logic [3:0]   ds_i;
  logic [W-1:0] dp_o;
  logic [3:0]   ds_o;
  logic         busy;
  logic         done;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] exp_word_q[$];
  logic [3:0]   exp_ser_q[$];

  always #5 clk = ~clk;

  sd_lane_sreg #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .load_i     (load),
    .shift_en_i (shift_en),
    .wide_i     (wide),
    .data_p_i   (dp_i),
    .data_s_i   (ds_i),
    .data_p_o   (dp_o),
    .data_s_o   (ds_o),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic check_word(input string tag);
    logic [W-1:0] e;
    if (exp_word_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed 0x%0h expected <scoreboard empty>", tag, dp_o);
    end else begin
      e = exp_word_q.pop_front();
      check(tag, 32'(dp_o), 32'(e));
    end
  endtask

  task automatic check_ser(input string tag);
    logic [3:0] e;
    if (exp_ser_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed 0x%0h expected <scoreboard empty>", tag, ds_o);
    end else begin
      e = exp_ser_q.pop_front();
      check(tag, 32'(ds_o), 32'(e));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    shift_en = 1'b1;
    cycle();
    shift_en = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] word, input logic w);
    load = 1'b1;
    dp_i = word;
    wide = w;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    logic [W-1:0] word;
    logic [3:0]   nib [4];

    rstn = 1'b0; load = 1'b0; shift_en = 1'b0; wide = 1'b0;
    dp_i = '0; ds_i = '0;

    // Reset state
    cycle(); cycle();
    check("rst_data_p", 32'(dp_o), 32'h0);
    check("rst_data_s", 32'(ds_o), 32'he);
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_done",   32'(done), 32'h0);
    rstn = 1'b1;
    cycle();

    // Narrow TX of 0xA5C3
    word = 16'hA5C3;
    for (int i = W - 1; i >= 0; i--) exp_ser_q.push_back({3'b111, word[i]});
    exp_word_q.push_back(16'h0000);
    ds_i = 4'h0;
    do_load(word, 1'b0);
    check("tx_load_data", 32'(dp_o), 32'hA5C3);
    check("tx_load_busy", 32'(busy), 32'h1);
    check("tx_load_done", 32'(done), 32'h0);
    for (int k = 1; k <= W; k++) begin
      check_ser("tx_ser");
      strobe();
      if (k < W) check("tx_early_done", 32'(done), 32'h0);
    end
    check("tx_done", 32'(done), 32'h1);
    check("tx_busy_fall", 32'(busy), 32'h0);
    check_word("tx_final_word");
    cycle();
    check("tx_done_single", 32'(done), 32'h0);

    // Wide RX of 0xDEAD
    nib[0] = 4'hD; nib[1] = 4'hE; nib[2] = 4'hA; nib[3] = 4'hD;
    exp_word_q.push_back(16'hDEAD);
    do_load(16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ds_i = nib[k];
      strobe();
      if (k < 3) begin
        check("rx_mid_busy", 32'(busy), 32'h1);
        check("rx_mid_done", 32'(done), 32'h0);
      end
    end
    check_word("rx_word");
    check("rx_busy_fall", 32'(busy), 32'h0);
    check("rx_done", 32'(done), 32'h1);
    check("rx_ser_wide", 32'(ds_o), 32'hD);

    // Gapped strobes, narrow, shifting in ones
    exp_word_q.push_back(16'h0FFF);
    exp_word_q.push_back(16'hFFFF);
    ds_i = 4'b0001;
    do_load(16'h0F0F, 1'b0);
    for (int k = 0; k < W; k++) begin
      repeat (k % 5 + 1) begin
        cycle();
        check("gap_idle_done", 32'(done), 32'h0);
        check("gap_idle_busy", 32'(busy), 32'h1);
      end
      strobe();
      if (k == 7) check_word("gap_half_word");
    end
    check("gap_done", 32'(done), 32'h1);
    check("gap_busy_fall", 32'(busy), 32'h0);
    check_word("gap_final_word");

    // Back-to-back words with load+strobe in the done cycle
    ds_i = 4'h0;
    do_load(16'h1234, 1'b0);
    repeat (W) strobe();
    check("b2b_first_done", 32'(done), 32'h1);
    load = 1'b1; shift_en = 1'b1; dp_i = 16'h5678; wide = 1'b0; ds_i = 4'hF;
    cycle();
    load = 1'b0; shift_en = 1'b0;
    check("b2b_reload_data", 32'(dp_o), 32'h5678);
    check("b2b_reload_busy", 32'(busy), 32'h1);
    check("b2b_reload_done", 32'(done), 32'h0);
    check("b2b_reload_ser",  32'(ds_o), 32'he);
    exp_word_q.push_back(16'hFFFF);
    for (int k = 1; k <= W; k++) begin
      strobe();
      if (k == W - 1) check("b2b_busy_hold", 32'(busy), 32'h1);
    end
    check("b2b_second_done", 32'(done), 32'h1);
    check_word("b2b_second_word");

    // Mode change mid-word is ignored until next load
    ds_i = 4'h0;
    do_load(16'h1234, 1'b1);
    strobe();
    wide = 1'b0;
    check("mode_ser_1", 32'(ds_o), 32'h2);
    strobe();
    check("mode_ser_2", 32'(ds_o), 32'h3);
    check("mode_done_early", 32'(done), 32'h0);
    strobe();
    check("mode_ser_3", 32'(ds_o), 32'h4);
    strobe();
    check("mode_done", 32'(done), 32'h1);
    check("mode_busy_fall", 32'(busy), 32'h0);
    check("mode_data", 32'(dp_o), 32'h0);

    // Asynchronous reset mid-word
    do_load(16'hBEEF, 1'b0);
    repeat (7) strobe();
    check("rstm_busy_before", 32'(busy), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("rstm_data_p", 32'(dp_o), 32'h0);
    check("rstm_busy",   32'(busy), 32'h0);
    check("rstm_data_s", 32'(ds_o), 32'he);
    check("rstm_done",   32'(done), 32'h0);
    cycle(); cycle();
    rstn = 1'b1;
    repeat (3) begin
      cycle();
      check("rstm_no_done", 32'(done), 32'h0);
    end
    ds_i = 4'b0001;
    strobe();
    check("free_busy", 32'(busy), 32'h0);
    check("free_done", 32'(done), 32'h0);
    check("free_data", 32'(dp_o), 32'h1);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sd_lane_sreg.md
# sd_lane_sreg

Parametrised parallel/serial shift register for the SD host data path. It serves both 1-bit and 4-bit SD bus widths and adds a built-in shift counter with word-complete signalling. It sits between the byte/word buffers and the DAT/CMD line drivers, serialising transmit words and deserialising receive words under a per-SD-clock shift strobe. It supersedes the fixed 16-bit, always-shifting register.

## Interface

Parameters:
- WIDTH, 16: register width in bits; multiple of 4, minimum 8.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- load_i  in  1  parallel load of data_p_i; arms the shift counter.
- shift_en_i  in  1  shift strobe, one cycle per SD bit time.
- wide_i  in  1  0 = 1-lane mode, 1 = 4-lane mode; sampled only on load_i.
- data_p_i  in  WIDTH  parallel load word.
- data_s_i  in  4  serial inputs; lane 0 is DAT0/CMD.
- data_p_o  out  WIDTH  register contents.
- data_s_o  out  4  serial outputs, MSB-first.
- busy_o  out  1  counter armed, shifts outstanding.
- done_o  out  1  single-cycle pulse: word fully shifted.

## Operation

- Registers: `sr` (WIDTH), `cnt` (clog2(WIDTH+1) bits), `wide_q`, `busy_q`, `done_q`.
- Reset values:
  - `sr` = 0, so data_p_o = 0.
  - `cnt` = 0, `wide_q` = 0, busy_o = 0, done_o = 0.
  - data_s_o = 4'b1110 (narrow mode: lanes 3:1 idle high, lane 0 = `sr`[WIDTH-1] = 0).
- Load (load_i=1):
  - `sr` ← data_p_i; `wide_q` ← wide_i.
  - `cnt` ← WIDTH if wide_i=0, else WIDTH/4.
  - busy ← 1; done ← 0.
- Shift (shift_en_i=1, load_i=0):
  - Narrow: `sr` ← {`sr`[WIDTH-2:0], data_s_i[0]}.
  - Wide: `sr` ← {`sr`[WIDTH-5:0], data_s_i[3:0]}.
- Serial out:
  - Narrow: data_s_o = {3'b111, `sr`[WIDTH-1]}.
  - Wide: data_s_o = `sr`[WIDTH-1:WIDTH-4], with DAT3 carrying the MSB.
- Counter: on a shift with busy=1, `cnt` decrements.
  - When `cnt` goes 1→0: busy ← 0, done ← 1 for one cycle.
- Shift with busy=0 still shifts `sr` (free-running capture for CRC/start-bit hunting). `cnt` holds 0, no done.
- load_i and shift_en_i together: load wins, no shift, counter re-armed.
  - This covers back-to-back words: a load in the same cycle done_o pulses starts the next word with no gap.
- done_o is cleared on any cycle without a terminal shift.
- wide_i changes while busy have no effect until the next load.
- Receive usage: load zeros to arm, shift in WIDTH/lanes bits, read data_p_o when done_o=1.

## Timing

- All outputs are registered or combinational from registers only. There is no input→output combinational path.
- Load takes effect in the cycle after the load_i edge. The first serial bit appears on data_s_o in the same cycle data_p_o updates.
- Each shift_en_i produces exactly one shift, visible the cycle after.
- done_o and the busy_o fall are asserted in the cycle after the last shift strobe. data_p_o holds the complete word in that cycle.
- Word latency: narrow = WIDTH strobes, wide = WIDTH/4 strobes, from load.
- Asynchronous reset mid-word: the operation aborts immediately and all state returns to reset values. No done_o is emitted.

## Structure

- Package `sd_sreg_pkg`:
  - `SD_LANES` = 4.
  - `sd_bus_width_t` enum {SD_BUS_1BIT, SD_BUS_4BIT}.
  - Function `sd_shift_count(width, bus)` returning the number of shift strobes per word.
- Sub-module `sd_sreg_cnt`: loadable down-counter with busy/done generation. It is reusable by the CRC and block-length logic.
- Top level: `sr` datapath, lane mux, instantiation of `sd_sreg_cnt`.

## Test plan

All scenarios use WIDTH=16.
- Narrow TX: load 0xA5C3, wide=0, 16 strobes → data_s_o[0] sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; lanes 3:1 stay 1; done_o pulses once after strobe 16.
- Wide RX: load 0, wide=1, 4 strobes with data_s_i = 0xD, 0xE, 0xA, 0xD → data_p_o = 0xDEAD; busy_o falls and done_o pulses together after strobe 4.
- Gapped strobes: narrow load, strobes spaced 1–5 idle cycles apart → `cnt` changes only on strobes; done_o after exactly 16 strobes.
- Back-to-back: load 0x1234; load 0x5678 in the done_o cycle, with a simultaneous strobe → no shift; new word is 0x5678; busy_o stays 1; second done_o after 16 more strobes.
- Mode change mid-word: load wide=1, toggle wide_i=0 after strobe 1 → 4-lane shifting continues; done_o after strobe 4.
- Reset mid-word: rstn_i low after strobe 7 of a narrow word → data_p_o=0, busy_o=0, data_s_o=4'b1110, no done_o; a free shift after release leaves busy_o at 0.
